// File: rtl/fetch_stage_pkg.sv
// Shared encodings for the fetch stage: halt-class opcodes, the bubble word
// and the fetch FSM states.
package fetch_stage_pkg;

   localparam logic [4:0]  OPCODE_SYSTEM    = 5'b11100;
   localparam logic [4:0]  OPCODE_MISC_MEM  = 5'b00011;
   localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_RUN    = 2'd0,
      FS_DRAIN  = 2'd1,
      FS_HALTED = 2'd2
   } fetch_state_e;

   // ECALL/EBREAK (SYSTEM, funct3=000) and every MISC-MEM word stop fetching.
   function automatic logic is_halt_inst(input logic [31:0] inst);
      logic sys_match;
      logic fence_match;
      sys_match   = (inst[1:0] == 2'b11) && (inst[6:2] == OPCODE_SYSTEM) &&
                    (inst[14:12] == 3'b000);
      fence_match = (inst[1:0] == 2'b11) && (inst[6:2] == OPCODE_MISC_MEM);
      return sys_match || fence_match;
   endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register. bubble wins over load; with neither asserted the
// register holds.
module ifid_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_inst,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc4,
   output logic [31:0] out_inst,
   output logic        out_valid
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc4_q, pc4_d;
   logic [31:0] inst_q, inst_d;
   logic        valid_q, valid_d;

   always_comb begin
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      inst_d  = inst_q;
      valid_d = valid_q;
      if (bubble) begin
         pc_d    = 32'h0;
         pc4_d   = 32'h0;
         inst_d  = NOP_INST;
         valid_d = 1'b0;
      end else if (load) begin
         pc_d    = in_pc;
         pc4_d   = in_pc + 32'd4;
         inst_d  = in_inst;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= 32'h0;
         pc4_q   <= 32'h0;
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
      end
   end

   assign out_pc    = pc_q;
   assign out_pc4   = pc4_q;
   assign out_inst  = inst_q;
   assign out_valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, IF/ID register, stall/redirect handling and the
// RUN -> DRAIN -> HALTED sequence triggered by ECALL/EBREAK/FENCE-class words.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] NOP_INST     = DEFAULT_NOP_INST,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] target_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc4,
   output logic [31:0] ifid_inst,
   output logic        ifid_valid,
   output logic [4:0]  ctrl_opcode,
   output logic        halted,
   output logic [1:0]  dbg_state
);

   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

   logic [31:0]  pc_q, pc_d;
   fetch_state_e state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         halted_q, halted_d;
   logic         ifid_load, ifid_bubble;
   logic         halt_match;

   assign halt_match = is_halt_inst(imem_rdata);

   always_comb begin
      pc_d        = pc_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      // halted trails the HALTED state by one edge.
      halted_d    = (state_q == FS_HALTED);
      case (state_q)
         FS_RUN, FS_DRAIN: begin
            if (redirect) begin
               pc_d        = target_pc & ~32'h3;
               ifid_bubble = 1'b1;
               state_d     = FS_RUN;
               cnt_d       = 4'd0;
            end else if (state_q == FS_DRAIN) begin
               // Stall is ignored here: the drain count always advances.
               ifid_bubble = 1'b1;
               cnt_d       = cnt_q + 4'd1;
               if (cnt_q == DRAIN_LAST) state_d = FS_HALTED;
            end else if (!stall) begin
               ifid_load = 1'b1;
               if (halt_match) begin
                  state_d = FS_DRAIN;
                  cnt_d   = 4'd0;
               end else begin
                  pc_d = pc_q + 32'd4;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         state_q  <= FS_RUN;
         cnt_q    <= 4'd0;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_d;
      end
   end

   ifid_reg #(.NOP_INST(NOP_INST)) u_ifid (
      .clk       (clk),
      .rst       (rst),
      .load      (ifid_load),
      .bubble    (ifid_bubble),
      .in_pc     (pc_q),
      .in_inst   (imem_rdata),
      .out_pc    (ifid_pc),
      .out_pc4   (ifid_pc4),
      .out_inst  (ifid_inst),
      .out_valid (ifid_valid)
   );

   assign imem_addr   = pc_q;
   assign ctrl_opcode = ifid_inst[6:2];
   assign halted      = halted_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each step drives one edge and queues the
// hand-computed post-edge outputs; a monitor pops and compares after every edge.
module tb_fetch_stage;

   localparam int W = 132;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] target_pc = 32'h0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] ifid_pc, ifid_pc4, ifid_inst;
   logic        ifid_valid;
   logic [4:0]  ctrl_opcode;
   logic        halted;
   logic [1:0]  dbg_state;

   logic [W-1:0] exp_q[$];
   int           id_q[$];
   int           n_checks = 0;
   int           n_pass = 0;
   int           step_no = 0;

   fetch_stage #(.RESET_PC(32'h0), .NOP_INST(32'h0000_0013), .DRAIN_CYCLES(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .target_pc   (target_pc),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .ifid_pc     (ifid_pc),
      .ifid_pc4    (ifid_pc4),
      .ifid_inst   (ifid_inst),
      .ifid_valid  (ifid_valid),
      .ctrl_opcode (ctrl_opcode),
      .halted      (halted),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   // Instruction memory: a few fixed words, everything else a distinct ADDI.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h00: return 32'h00B5_0533; // add  x10,x10,x11
         32'h04: return 32'h0015_0513; // addi x10,x10,1
         32'h08: return 32'h0005_2583; // lw   x11,0(x10)
         32'h20: return 32'h0000_0073; // ecall
         32'h30: return 32'h0FF0_000F; // fence
         32'h50: return 32'h0010_2073; // csrrs, funct3!=0: not a halt
         default: return {a[21:2], 12'h093};
      endcase
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL step%0d %s: got %h expected %h", id, name, act, exp);
   endtask

   // One clock edge with the given inputs; exp_* describe outputs after the edge.
   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] tgt,
                       input logic [31:0] e_addr, input logic [31:0] e_pc,
                       input logic [31:0] e_inst, input logic e_v, input logic e_h,
                       input logic [1:0] e_st);
      logic [31:0] e_pc4;
      @(negedge clk);
      rst       = r;
      stall     = s;
      redirect  = rd;
      target_pc = tgt;
      e_pc4     = e_v ? e_pc + 32'd4 : 32'h0;
      step_no++;
      exp_q.push_back({e_st, e_h, e_v, e_inst, e_pc4, e_pc, e_addr});
      id_q.push_back(step_no);
   endtask

   initial begin : monitor
      logic [W-1:0] e;
      int           id;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            chk(id, "imem_addr",   imem_addr,          e[31:0]);
            chk(id, "ifid_pc",     ifid_pc,            e[63:32]);
            chk(id, "ifid_pc4",    ifid_pc4,           e[95:64]);
            chk(id, "ifid_inst",   ifid_inst,          e[127:96]);
            chk(id, "ctrl_opcode", {27'h0, ctrl_opcode}, {27'h0, e[102:98]});
            chk(id, "ifid_valid",  {31'h0, ifid_valid},  {31'h0, e[128]});
            chk(id, "halted",      {31'h0, halted},      {31'h0, e[129]});
            chk(id, "state",       {30'h0, dbg_state},   {30'h0, e[131:130]});
         end
      end
   end

   localparam logic [31:0] NOP = 32'h0000_0013;

   initial begin : driver
      //    rst  stl  rdr  target          addr          ifid_pc       inst          v     h     st
      step(1'b1,1'b0,1'b0,32'h0,         32'h0,        32'h0,        NOP,          1'b0,1'b0,2'd0);
      step(1'b1,1'b1,1'b1,32'h80,        32'h0,        32'h0,        NOP,          1'b0,1'b0,2'd0);
      // Clean fetches, then a two-cycle stall at pc=0x8
      step(1'b0,1'b0,1'b0,32'h0,         32'h4,        32'h0,        32'h00B50533, 1'b1,1'b0,2'd0);
      step(1'b0,1'b0,1'b0,32'h0,         32'h8,        32'h4,        32'h00150513, 1'b1,1'b0,2'd0);
      step(1'b0,1'b1,1'b0,32'h0,         32'h8,        32'h4,        32'h00150513, 1'b1,1'b0,2'd0);
      step(1'b0,1'b1,1'b0,32'h0,         32'h8,        32'h4,        32'h00150513, 1'b1,1'b0,2'd0);
      step(1'b0,1'b0,1'b0,32'h0,         32'hC,        32'h8,        32'h00052583, 1'b1,1'b0,2'd0);
      step(1'b0,1'b0,1'b0,32'h0,         32'h10,       32'hC,        32'h00003093, 1'b1,1'b0,2'd0);
      // Redirect with stall, misaligned target
      step(1'b0,1'b1,1'b1,32'h103,       32'h100,      32'h0,        NOP,          1'b0,1'b0,2'd0);
      step(1'b0,1'b0,1'b0,32'h0,         32'h104,      32'h100,      32'h00040093, 1'b1,1'b0,2'd0);
      // ECALL at 0x20: drain (stall mid-drain), halt, redirect ignored
      step(1'b0,1'b0,1'b1,32'h20,        32'h20,       32'h0,        NOP,          1'b0,1'b0,2'd0);
      step(1'b0,1'b0,1'b0,32'h0,         32'h20,       32'h20,       32'h00000073, 1'b1,1'b0,2'd1);
      step(1'b0,1'b0,1'b0,32'h0,         32'h20,       32'h0,        NOP,          1'b0,1'b0,2'd1);
      step(1'b0,1'b1,1'b0,32'h0,         32'h20,       32'h0,        NOP,          1'b0,1'b0,2'd1);
      step(1'b0,1'b0,1'b0,32'h0,         32'h20,       32'h0,        NOP,          1'b0,1'b0,2'd2);
      step(1'b0,1'b1,1'b0,32'h0,         32'h20,       32'h0,        NOP,          1'b0,1'b1,2'd2);
      step(1'b0,1'b0,1'b1,32'h40,        32'h20,       32'h0,        NOP,          1'b0,1'b1,2'd2);
      step(1'b1,1'b0,1'b0,32'h0,         32'h0,        32'h0,        NOP,          1'b0,1'b0,2'd0);
      // FENCE at 0x30, redirect on second drain cycle cancels the halt
      step(1'b0,1'b0,1'b1,32'h30,        32'h30,       32'h0,        NOP,          1'b0,1'b0,2'd0);
      step(1'b0,1'b0,1'b0,32'h0,         32'h30,       32'h30,       32'h0FF0000F, 1'b1,1'b0,2'd1);
      step(1'b0,1'b0,1'b0,32'h0,         32'h30,       32'h0,        NOP,          1'b0,1'b0,2'd1);
      step(1'b0,1'b0,1'b1,32'h40,        32'h40,       32'h0,        NOP,          1'b0,1'b0,2'd0);
      step(1'b0,1'b0,1'b0,32'h0,         32'h44,       32'h40,       32'h00010093, 1'b1,1'b0,2'd0);
      step(1'b0,1'b0,1'b0,32'h0,         32'h48,       32'h44,       32'h00011093, 1'b1,1'b0,2'd0);
      step(1'b0,1'b0,1'b0,32'h0,         32'h4C,       32'h48,       32'h00012093, 1'b1,1'b0,2'd0);
      // PC wrap at the top of the address space
      step(1'b0,1'b0,1'b1,32'hFFFFFFFC,  32'hFFFFFFFC, 32'h0,        NOP,          1'b0,1'b0,2'd0);
      step(1'b0,1'b0,1'b0,32'h0,         32'h0,        32'hFFFFFFFC, 32'hFFFFF093, 1'b1,1'b0,2'd0);
      // Reset in the middle of a drain
      step(1'b0,1'b0,1'b1,32'h20,        32'h20,       32'h0,        NOP,          1'b0,1'b0,2'd0);
      step(1'b0,1'b0,1'b0,32'h0,         32'h20,       32'h20,       32'h00000073, 1'b1,1'b0,2'd1);
      step(1'b0,1'b0,1'b0,32'h0,         32'h20,       32'h0,        NOP,          1'b0,1'b0,2'd1);
      step(1'b1,1'b1,1'b1,32'h40,        32'h0,        32'h0,        NOP,          1'b0,1'b0,2'd0);
      step(1'b0,1'b0,1'b0,32'h0,         32'h4,        32'h0,        32'h00B50533, 1'b1,1'b0,2'd0);
      // SYSTEM opcode with nonzero funct3 keeps running
      step(1'b0,1'b0,1'b1,32'h50,        32'h50,       32'h0,        NOP,          1'b0,1'b0,2'd0);
      step(1'b0,1'b0,1'b0,32'h0,         32'h54,       32'h50,       32'h00102073, 1'b1,1'b0,2'd0);
      step(1'b0,1'b0,1'b0,32'h0,         32'h58,       32'h54,       32'h00015093, 1'b1,1'b0,2'd0);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
